// File: rtl/hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : hazard_ctrl
// Brief    : Forwarding selects, load-use stall and branch-squash sequencing
//            for the five-stage core, with optional saturating event counters
//            (enabled by defining HAZARD_PERF_CNT_EN).
// Revision : 1.0  initial release
//============================================================================
module hazard_ctrl #(
   parameter int SQUASH_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rs1_E,
   input  logic [4:0]       rs2_E,
   input  logic [4:0]       rd_E,
   input  logic             regwrt_E,
   input  logic             resultctrl_E,
   input  logic [4:0]       rd_M,
   input  logic             regwrt_M,
   input  logic [4:0]       rd_W,
   input  logic             regwrt_W,
   input  logic             branch_taken_E,
   output logic [1:0]       FrwdA_E,
   output logic [1:0]       FrwdB_E,
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_D,
   output logic             flush_E,
   output logic             squash_active,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] c_ST_RUN     = 2'd0;
   localparam logic [1:0] c_ST_LDSTALL = 2'd1;
   localparam logic [1:0] c_ST_SQUASH  = 2'd2;
   localparam logic [2:0] c_SQ_INIT    = 3'(SQUASH_CYCLES - 1);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic [2:0] r_sq_cnt;
   logic [2:0] w_sq_nxt;
   logic       r_squash_active;
   logic       w_lu;
   logic       w_take_br;
   logic       w_stall;

   // Memory stage wins over writeback; x0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rdm, input logic wem,
                                          input logic [4:0] rdw, input logic wew);
      if (wem && (rdm != 5'd0) && (rdm == rs))
         return 2'b10;
      else if (wew && (rdw != 5'd0) && (rdw == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign w_lu = resultctrl_E & regwrt_E & (rd_E != 5'd0) &
                 ((rd_E == rs1_D) | (rd_E == rs2_D));
   assign w_take_br = branch_taken_E & (r_state != c_ST_SQUASH);
   assign w_stall   = (r_state == c_ST_RUN) & ~branch_taken_E & w_lu;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= c_ST_RUN;
         r_sq_cnt        <= 3'd0;
         r_squash_active <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_sq_cnt        <= w_sq_nxt;
         r_squash_active <= (w_state_nxt == c_ST_SQUASH);
      end
   end

   always_comb begin
      w_state_nxt = c_ST_RUN;
      w_sq_nxt    = r_sq_cnt;
      case (r_state)
         c_ST_RUN, c_ST_LDSTALL: begin
            if (w_take_br) begin
               if (SQUASH_CYCLES > 1) begin
                  w_state_nxt = c_ST_SQUASH;
                  w_sq_nxt    = c_SQ_INIT;
               end
            end else if (w_stall) begin
               w_state_nxt = c_ST_LDSTALL;
            end
         end
         c_ST_SQUASH: begin
            if (r_sq_cnt <= 3'd1) begin
               w_sq_nxt = 3'd0;
            end else begin
               w_state_nxt = c_ST_SQUASH;
               w_sq_nxt    = r_sq_cnt - 3'd1;
            end
         end
         default: w_state_nxt = c_ST_RUN;
      endcase
   end

   // Controls are forced quiet while reset is asserted, independent of inputs.
   always_comb begin
      FrwdA_E = 2'b00;
      FrwdB_E = 2'b00;
      stall_F = 1'b0;
      stall_D = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      if (!rst) begin
         FrwdA_E = fwd_sel(rs1_E, rd_M, regwrt_M, rd_W, regwrt_W);
         FrwdB_E = fwd_sel(rs2_E, rd_M, regwrt_M, rd_W, regwrt_W);
         stall_F = w_stall;
         stall_D = w_stall;
         flush_D = w_take_br;
         flush_E = w_take_br | w_stall | (r_state == c_ST_SQUASH);
      end
   end

   assign squash_active = r_squash_active;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_take_br && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed self-checking bench for hazard_ctrl (SQUASH_CYCLES=3,
//            CNT_W=4); counter expectations follow HAZARD_PERF_CNT_EN.
// Revision : 1.0  initial release
//============================================================================
module tb_hazard_ctrl;

   localparam int SQ = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic          regwrt_E, resultctrl_E, regwrt_M, regwrt_W, branch_taken_E;
   logic [1:0]    FrwdA_E, FrwdB_E;
   logic          stall_F, stall_D, flush_D, flush_E, squash_active;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   hazard_ctrl #(.SQUASH_CYCLES(SQ), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
      .rd_E(rd_E), .regwrt_E(regwrt_E), .resultctrl_E(resultctrl_E),
      .rd_M(rd_M), .regwrt_M(regwrt_M), .rd_W(rd_W), .regwrt_W(regwrt_W),
      .branch_taken_E(branch_taken_E),
      .FrwdA_E(FrwdA_E), .FrwdB_E(FrwdB_E),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
      .squash_active(squash_active), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
      return (v > 15) ? 15 : v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic clr_in();
      rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
      regwrt_E = 0; resultctrl_E = 0; regwrt_M = 0; regwrt_W = 0;
      branch_taken_E = 0;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // {stall_F, stall_D, flush_D, flush_E}
   task automatic chk_ctl(input string tag, input logic [3:0] exp);
      chk(tag, int'({stall_F, stall_D, flush_D, flush_E}), int'(exp));
   endtask

   task automatic set_lu();
      resultctrl_E = 1; regwrt_E = 1; rd_E = 5'd7; rs2_D = 5'd7;
   endtask

   initial begin
      clr_in();
      // Hazards present while reset is held must not reach the controls
      rd_M = 5; regwrt_M = 1; rs1_E = 5; rs2_E = 5; branch_taken_E = 1; set_lu();
      #2;
      chk("rst_frwdA", FrwdA_E, 0);
      chk("rst_frwdB", FrwdB_E, 0);
      chk_ctl("rst_ctl", 4'b0000);
      nxt();
      chk("rst_sqact", squash_active, 0);
      chk("rst_scnt", stall_cnt, 0);
      chk("rst_fcnt", flush_cnt, 0);
      clr_in();
      rst = 0;
      nxt();

      // Forwarding priority
      rd_M = 5; rd_W = 5; regwrt_M = 1; regwrt_W = 1; rs1_E = 5; rs2_E = 5;
      #1;
      chk("fwd_mem_A", FrwdA_E, 2);
      chk("fwd_mem_B", FrwdB_E, 2);
      regwrt_M = 0; #1;
      chk("fwd_wb_A", FrwdA_E, 1);
      chk("fwd_wb_B", FrwdB_E, 1);
      regwrt_M = 1; rd_M = 0; rd_W = 0; rs1_E = 0; rs2_E = 0; #1;
      chk("fwd_x0_A", FrwdA_E, 0);
      chk("fwd_x0_B", FrwdB_E, 0);
      rd_M = 4; rd_W = 3; rs1_E = 3; rs2_E = 4; #1;
      chk("fwd_mix_A", FrwdA_E, 1);
      chk("fwd_mix_B", FrwdB_E, 2);
      clr_in();

      // Load-use bubble
      set_lu(); #1;
      chk_ctl("lu_ctl", 4'b1101);
      nxt(); exp_stall++;
      clr_in(); #1;
      chk_ctl("ldstall_ctl", 4'b0000);
      chk("lu_scnt", stall_cnt, cnt_exp(exp_stall));
      chk("ldstall_sqact", squash_active, 0);
      nxt();
      set_lu(); #1;
      chk_ctl("lu_again_run", 4'b1101);
      nxt(); exp_stall++;
      clr_in();
      nxt();
      rd_E = 5'd0; resultctrl_E = 1; regwrt_E = 1; #1;
      chk_ctl("lu_x0", 4'b0000);
      clr_in();

      // Branch squash, second branch in cycle 2 ignored
      branch_taken_E = 1; #1;
      chk_ctl("br_c1", 4'b0011);
      chk("br_c1_sqact", squash_active, 0);
      nxt(); exp_flush++;
      #1;
      chk_ctl("br_c2", 4'b0001);
      chk("br_c2_sqact", squash_active, 1);
      nxt();
      branch_taken_E = 0; #1;
      chk_ctl("br_c3", 4'b0001);
      chk("br_c3_sqact", squash_active, 1);
      nxt();
      chk_ctl("br_c4", 4'b0000);
      chk("br_c4_sqact", squash_active, 0);
      chk("br_fcnt", flush_cnt, cnt_exp(exp_flush));

      // Simultaneous load-use and branch
      set_lu(); branch_taken_E = 1; #1;
      chk_ctl("lubr_ctl", 4'b0011);
      nxt(); exp_flush++;
      clr_in(); #1;
      chk("lubr_scnt", stall_cnt, cnt_exp(exp_stall));
      chk("lubr_fcnt", flush_cnt, cnt_exp(exp_flush));
      nxt(); nxt();
      chk("lubr_done", squash_active, 0);

      // Asynchronous reset in squash cycle 2
      branch_taken_E = 1;
      nxt(); exp_flush++;
      branch_taken_E = 0; #1;
      chk("ar_pre_sqact", squash_active, 1);
      rd_M = 5; regwrt_M = 1; rs1_E = 5;
      rst = 1; #1;
      chk_ctl("ar_ctl", 4'b0000);
      chk("ar_frwdA", FrwdA_E, 0);
      chk("ar_sqact", squash_active, 0);
      chk("ar_scnt", stall_cnt, 0);
      chk("ar_fcnt", flush_cnt, 0);
      exp_stall = 0; exp_flush = 0;
      #1 rst = 0; #1;
      chk_ctl("ar_rel_ctl", 4'b0000);
      nxt();
      chk_ctl("ar_run_ctl", 4'b0000);
      chk("ar_run_sqact", squash_active, 0);
      clr_in();

      // Counter saturation
      for (int i = 0; i < 20; i++) begin
         set_lu();
         nxt(); exp_stall++;
         clr_in();
         nxt();
      end
      chk("sat_scnt", stall_cnt, cnt_exp(exp_stall));
      chk("sat_fcnt", flush_cnt, cnt_exp(exp_flush));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
